// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// bus widths, the write-request payload and the word-to-byte address rule
// also used by the memory and the CPU fetch path.
package instr_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned ADDR_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_req_t;

    // Byte address of instruction word w; the read side fetches at addr >> 2.
    function automatic logic [ADDR_W-1:0] word_byte_addr(input logic [ADDR_W-1:0] w);
        return w << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and memory write-port signals of the instruction loader.
//   master : program source / memory side (drives bytes, receives writes)
//   slave  : the loader (accepts bytes, drives writes)
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output byte_in, byte_valid, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/instr_loader.sv
// Instruction loader: packs a byte stream (MSB first) into 32-bit words and
// writes them to consecutive instruction-memory byte addresses 0, 4, 8, ...
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   start                1-cycle pulse, begins a load from IDLE/DONE/ERR
//   bus (slave)          byte valid/ready input and memory write port
//   busy, done, error    load status (registered)
//   word_count           words written in the current/last load
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    instr_loader_if.slave    bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;

    logic                hs_c;
    logic [WORD_W-1:0]   shift_nxt_c;

    assign hs_c        = bus.byte_valid & ready_q;
    assign shift_nxt_c = {shift_q[WORD_W-BYTE_W-1:0], bus.byte_in};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        last_d    = last_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        ready_d   = ready_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_RECV;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    count_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end

            ST_RECV: begin
                if (hs_c) begin
                    shift_d = shift_nxt_c;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(3)) begin
                        // Memory full: refuse the word rather than write past the top.
                        if (count_q == CNT_W'(DEPTH)) begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            ready_d = 1'b0;
                        end else begin
                            state_d   = ST_WRITE;
                            last_d    = bus.byte_last;
                            ready_d   = 1'b0;
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_nxt_c;
                            wr_addr_d = word_byte_addr(ADDR_W'(count_q));
                        end
                    end else if (bus.byte_last) begin
                        // Program ended mid-word: abort without a write.
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                    end
                end
            end

            ST_WRITE: begin
                count_d = count_q + CNT_W'(1);
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_RECV;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also cuts off any in-flight write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed byte streams, expected memory writes
// queued at issue time and matched by an independent write monitor.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             clock = 1'b0;
    logic             resetn;
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] word_count;

    instr_loader_if bus();

    instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    wr_req_t sb[$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest expected write.
    initial begin
        wr_req_t e;
        forever begin
            @(negedge clock);
            check("done_error_exclusive", 32'(done & error), 32'd0);
            if (bus.wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h at %0t",
                             bus.wr_addr, bus.wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
                end
            end
        end
    end

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        wr_req_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    // All driving tasks begin and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        bus.byte_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clock);
            #1;
        end
        bus.byte_in    = b;
        bus.byte_last  = last;
        bus.byte_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (bus.byte_ready === 1'b1) begin
                @(posedge clock);
                #1;
                bus.byte_valid = 1'b0;
                bus.byte_last  = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL byte_handshake_timeout: byte %h never accepted", b);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], last && (i == 3), rnd ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic wait_end(input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (done === 1'b1 || error === 1'b1) begin
                @(posedge clock);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: done %b error %b", name, done, error);
    endtask

    task automatic end_checks(input string name, input bit exp_done, input bit exp_err,
                              input int exp_cnt);
        check({name, "_done"},       32'(done),           32'(exp_done));
        check({name, "_error"},      32'(error),          32'(exp_err));
        check({name, "_busy"},       32'(busy),           32'd0);
        check({name, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({name, "_word_count"}, 32'(word_count),     32'(exp_cnt));
        check({name, "_pending"},    32'(sb.size()),      32'd0);
    endtask

    initial begin
        logic [31:0] w;
        resetn         = 1'b0;
        start          = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("rst_wr_addr",    bus.wr_addr,         32'd0);
        check("rst_wr_data",    bus.wr_data,         32'd0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_done",       32'(done),           32'd0);
        check("rst_error",      32'(error),          32'd0);
        check("rst_word_count", 32'(word_count),     32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Single word, MSB first, 1-cycle write latency
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        expect_write(32'd0, 32'h12345678);
        send_word(32'h12345678, 1'b1, 1'b0);
        @(negedge clock);
        check("t1_wr_latency", 32'(bus.wr_en), 32'd1);
        wait_end("t1");
        end_checks("t1", 1'b1, 1'b0, 1);

        // Three words with irregular byte_valid gaps
        pulse_start();
        expect_write(32'd0, 32'hDEADBEEF);
        expect_write(32'd4, 32'h00000013);
        expect_write(32'd8, 32'hA5C30F81);
        send_word(32'hDEADBEEF, 1'b0, 1'b1);
        send_word(32'h00000013, 1'b0, 1'b1);
        send_word(32'hA5C30F81, 1'b1, 1'b1);
        wait_end("t2");
        end_checks("t2", 1'b1, 1'b0, 3);

        // Partial final word aborts after exactly one write
        pulse_start();
        expect_write(32'd0, 32'h11223344);
        send_word(32'h11223344, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b1, 0);
        wait_end("t3");
        end_checks("t3", 1'b0, 1'b1, 1);
        bus.byte_in    = 8'h77;
        bus.byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("t3_err_ready", 32'(bus.byte_ready), 32'd0);
        end
        @(posedge clock);
        #1 bus.byte_valid = 1'b0;
        check("t3_err_hold", 32'(error), 32'd1);

        // Overflow: 33 words into a 32-word memory
        pulse_start();
        for (int i = 0; i < 33; i++) begin
            w = 32'h10203040 + 32'(i) * 32'h01010101;
            if (i < 32) expect_write(32'(4 * i), w);
            send_word(w, i == 32, 1'b0);
        end
        wait_end("t4");
        end_checks("t4", 1'b0, 1'b1, 32);

        // Reset while a write is on the bus
        pulse_start();
        expect_write(32'd0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        send_word(32'h13572468, 1'b0, 1'b0);
        check("t5_wr_before_rst", 32'(bus.wr_en), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("t5_rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("t5_rst_busy",       32'(busy),           32'd0);
        check("t5_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("t5_rst_word_count", 32'(word_count),     32'd0);
        check("t5_rst_wr_addr",    bus.wr_addr,         32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;
        pulse_start();
        expect_write(32'd0, 32'h0BADC0DE);
        send_word(32'h0BADC0DE, 1'b1, 1'b0);
        wait_end("t5");
        end_checks("t5", 1'b1, 1'b0, 1);

        // start mid-load is ignored; bytes offered in DONE are not consumed
        pulse_start();
        expect_write(32'd0, 32'hAABBCCDD);
        expect_write(32'd4, 32'h01020304);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        pulse_start();
        check("t6_busy_after_start", 32'(busy), 32'd1);
        send_byte(8'hCC, 1'b0, 0);
        send_byte(8'hDD, 1'b0, 0);
        send_word(32'h01020304, 1'b1, 1'b0);
        wait_end("t6");
        end_checks("t6", 1'b1, 1'b0, 2);
        bus.byte_in    = 8'hEE;
        bus.byte_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("t6_done_ready", 32'(bus.byte_ready), 32'd0);
            check("t6_done_hold",  32'(done),           32'd1);
        end
        @(posedge clock);
        #1 bus.byte_valid = 1'b0;
        pulse_start();
        check("t6_restart_done",  32'(done),           32'd0);
        check("t6_restart_busy",  32'(busy),           32'd1);
        check("t6_restart_count", 32'(word_count),     32'd0);
        check("t6_restart_ready", 32'(bus.byte_ready), 32'd1);
        expect_write(32'd0, 32'h55667788);
        send_word(32'h55667788, 1'b1, 1'b0);
        wait_end("t6b");
        end_checks("t6b", 1'b1, 1'b0, 1);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
